// File: rtl/pynq_axil_regs.sv
// rtl/pynq_axil_regs.sv - AXI4-Lite register window: CTRL, two scratch words, cycle counter, ID.
module pynq_axil_regs #(
    parameter int          C_ADDR_WIDTH = 5,
    parameter logic [31:0] C_ID_VALUE   = 32'h5059_0001
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        awready_q, awready_d, aw_held_q, aw_held_d;
    logic [2:0]  aw_addr_q, aw_addr_d;
    logic        wready_q, wready_d, w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d, ar_held_q, ar_held_d;
    logic [31:0] rd_snap_q, rd_snap_d;
    logic [1:0]  rd_resp_q, rd_resp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        en_q, en_d;
    logic [31:0] scratch0_q, scratch0_d, scratch1_q, scratch1_d, count_q, count_d;
    logic        clr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        en_d       = en_q;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        clr        = 1'b0;
        if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR[4:2];
        end
        if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        // Commit once both halves are held; bvalid_q doubles as the "already committed" flag.
        if (aw_held_q && w_held_q && !bvalid_q) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (aw_addr_q)
                3'd0: if (w_strb_q[0]) begin
                    en_d = w_data_q[0];
                    clr  = w_data_q[1];
                end
                3'd1: scratch0_d = merge(scratch0_q, w_data_q, w_strb_q);
                3'd2: scratch1_d = merge(scratch1_q, w_data_q, w_strb_q);
                3'd3, 3'd4: ;
                default: bresp_d = RESP_SLVERR;
            endcase
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        count_d   = clr ? 32'd0 : (en_q ? count_q + 32'd1 : count_q);
    end

    // Read data is snapshotted at AR capture so a same-edge write commit is not visible.
    always_comb begin
        ar_held_d = ar_held_q;
        rd_snap_d = rd_snap_q;
        rd_resp_d = rd_resp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (S_AXI_ARVALID && arready_q) begin
            ar_held_d = 1'b1;
            rd_resp_d = RESP_OKAY;
            case (S_AXI_ARADDR[4:2])
                3'd0:    rd_snap_d = {31'd0, en_q};
                3'd1:    rd_snap_d = scratch0_q;
                3'd2:    rd_snap_d = scratch1_q;
                3'd3:    rd_snap_d = count_q;
                3'd4:    rd_snap_d = C_ID_VALUE;
                default: begin
                    rd_snap_d = 32'd0;
                    rd_resp_d = RESP_SLVERR;
                end
            endcase
        end
        if (ar_held_q && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_snap_q;
            rresp_d  = rd_resp_q;
        end
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d  = 1'b0;
            ar_held_d = 1'b0;
        end
        arready_d = !ar_held_d;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_addr_q  <= 3'd0;
            wready_q   <= 1'b0;
            w_held_q   <= 1'b0;
            w_data_q   <= 32'd0;
            w_strb_q   <= 4'd0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'd0;
            arready_q  <= 1'b0;
            ar_held_q  <= 1'b0;
            rd_snap_q  <= 32'd0;
            rd_resp_q  <= 2'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'd0;
            en_q       <= 1'b0;
            scratch0_q <= 32'd0;
            scratch1_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            awready_q  <= awready_d;
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            wready_q   <= wready_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            ar_held_q  <= ar_held_d;
            rd_snap_q  <= rd_snap_d;
            rd_resp_q  <= rd_resp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            en_q       <= en_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            count_q    <= count_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_pynq_axil_regs.sv
// tb/tb_pynq_axil_regs.sv - randomized self-checking bench for pynq_axil_regs against a register-map model.
module tb_pynq_axil_regs;
    localparam logic [31:0] ID = 32'h5059_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pynq_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: registers as plain variables; COUNT as a linear function of the clock-edge index.
    logic [31:0] m_s0, m_s1, m_base;
    bit          m_en;
    int          m_base_edge;

    function automatic logic [31:0] m_count_after(input int e);
        return m_en ? m_base + 32'(e - m_base_edge) : m_base;
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_s0 = 0; m_s1 = 0; m_base = 0; m_en = 0; m_base_edge = cyc;
    endtask

    task automatic m_write(input int off, input logic [31:0] d, input logic [3:0] s, input int c);
        if (off == 0 && s[0]) begin
            m_base = d[1] ? 32'd0 : m_count_after(c);
            m_base_edge = c;
            m_en = d[0];
        end else if (off == 1) m_s0 = bytes_merge(m_s0, d, s);
        else if (off == 2) m_s1 = bytes_merge(m_s1, d, s);
    endtask

    task automatic m_read(input int off, input int r, output logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (off)
            0: d = {31'd0, m_en};
            1: d = m_s0;
            2: d = m_s1;
            3: d = m_count_after(r - 1);
            4: d = ID;
            default: begin d = 0; resp = 2'b10; end
        endcase
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int commit);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && !(awready && wready); i++) @(negedge clk);
        check("wr_ready_timeout", {31'd0, awready && wready}, 1);
        @(posedge clk);
        @(negedge clk);
        commit = cyc + 1;
        awvalid = 0; wvalid = 0;
        check("b_early", {31'd0, bvalid}, 0);
        @(negedge clk);
        check("b_valid", {31'd0, bvalid}, 1);
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("b_drop", {31'd0, bvalid}, 0);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int r);
        @(negedge clk);
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && !arready; i++) @(negedge clk);
        check("rd_ready_timeout", {31'd0, arready}, 1);
        @(posedge clk);
        @(negedge clk);
        r = cyc;
        arvalid = 0;
        check("r_early", {31'd0, rvalid}, 0);
        @(negedge clk);
        check("r_valid", {31'd0, rvalid}, 1);
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("r_drop", {31'd0, rvalid}, 0);
    endtask

    task automatic do_write(input int off, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] resp;
        int c;
        axi_write(5'(off * 4), d, s, resp, c);
        m_write(off, d, s, c);
        check($sformatf("bresp@%0h", off * 4), {30'd0, resp}, (off <= 4) ? 32'd0 : 32'd2);
    endtask

    task automatic do_read(input int off, output logic [31:0] d);
        logic [1:0] resp, eresp;
        logic [31:0] ed;
        int r;
        axi_read(5'(off * 4), d, resp, r);
        m_read(off, r, ed, eresp);
        check($sformatf("rdata@%0h", off * 4), d, ed);
        check($sformatf("rresp@%0h", off * 4), {30'd0, resp}, {30'd0, eresp});
    endtask

    initial begin
        logic [31:0] d;
        int cw;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outs", {27'd0, bvalid, rvalid, awready, wready, arready}, 0);
        end
        rst_n = 1;
        check("ready_before_edge", {29'd0, awready, wready, arready}, 0);
        @(negedge clk);
        check("ready_after_edge", {29'd0, awready, wready, arready}, 3'b111);
        m_reset();
        do_read(4, d);

        do_write(1, 32'hDEADBEEF, 4'hF);
        do_write(1, 32'h000000AA, 4'h1);
        do_read(1, d);
        check("strobe_merge", d, 32'hDEADBEAA);

        // W three cycles ahead of AW, then B held off for five cycles.
        @(negedge clk);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        check("w_captured", {30'd0, wready, awready}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        awaddr = 5'h08; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        cw = cyc + 1;
        check("bp_no_early_commit", {31'd0, bvalid}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {28'd0, bvalid, bresp, awready | wready}, 4'b1000);
        end
        m_write(2, 32'h1234_5678, 4'hF, cw);
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bp_release", {29'd0, bvalid, awready, wready}, 3'b011);
        do_read(2, d);

        do_write(0, 32'h1, 4'hF);
        repeat (100) @(negedge clk);
        do_read(3, d);
        check("count_range", {31'd0, d >= 100 && d <= 110}, 1);
        do_write(0, 32'h3, 4'hF);
        do_read(0, d);
        check("ctrl_clr_reads_0", d, 32'h1);
        do_read(3, d);

        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFF0;
        m_base = 32'hFFFF_FFF0; m_base_edge = cyc;
        #1 release dut.count_q;
        repeat (25) @(negedge clk);
        do_read(3, d);
        check("count_wrapped", {31'd0, d < 32'd100}, 1);

        do_write(6, 32'hFFFF_FFFF, 4'hF);
        do_read(7, d);
        do_write(4, 32'h0, 4'hF);
        do_read(4, d);

        for (int i = 0; i < 40; i++) begin
            int off;
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) do_write(off, $urandom, 4'($urandom));
            else do_read(off, d);
        end
        do_write(1, 32'hA5A5_0001, 4'hF);
        do_write(0, 32'h1, 4'hF);

        // Reset between AR capture and the RVALID edge.
        @(negedge clk);
        araddr = 5'h04; arvalid = 1;
        @(posedge clk);
        #2 rst_n = 0;
        arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_read", {28'd0, rvalid, bvalid, awready, arready}, 0);
        end
        rst_n = 1;
        @(negedge clk);
        check("rst_ready", {29'd0, awready, wready, arready}, 3'b111);
        m_reset();
        for (int off = 0; off < 4; off++) do_read(off, d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1);
    end
endmodule
